// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - scoreboard-based hazard, forwarding and stall/flush controller
// Entry e[s] mirrors the instruction held in pipeline register s, for s = 2..NUM_STAGES-1.
module pipeline_hazard_ctrl #(
  parameter int NUM_STAGES   = 5,
  parameter int REG_AW       = 5,
  parameter int BRANCH_STAGE = 3,
  parameter int MC_LAT       = 4,
  parameter int FWD_W        = $clog2(NUM_STAGES - 1)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  d_valid,
  input  logic [REG_AW-1:0]     d_ra0,
  input  logic [REG_AW-1:0]     d_ra1,
  input  logic                  d_use0,
  input  logic                  d_use1,
  input  logic                  d_rf_we,
  input  logic [REG_AW-1:0]     d_wa,
  input  logic                  d_is_load,
  input  logic                  d_multicycle,
  input  logic                  branch_taken,
  input  logic                  clear_stats,
  output logic [NUM_STAGES-1:0] stall,
  output logic [NUM_STAGES-1:0] flush,
  output logic [FWD_W-1:0]      fwd_sel0,
  output logic [FWD_W-1:0]      fwd_sel1,
  output logic                  busy,
  output logic [15:0]           stall_cycles
);

  localparam int CNT_W = (MC_LAT > 1) ? $clog2(MC_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MC_LAT - 1);

  logic [NUM_STAGES-1:2] e_valid;
  logic [NUM_STAGES-1:2] e_we;
  logic [NUM_STAGES-1:2] e_load;
  logic [NUM_STAGES-1:2] e_mc;
  logic [NUM_STAGES-1:2] live;
  logic [REG_AW-1:0]     e_wa [2:NUM_STAGES-1];
  logic [CNT_W-1:0]      cnt;
  logic                  load_use;
  logic                  mc_enter;
  logic                  mc_cancel;

  // A writer to register 0 is never live, so $0 neither forwards nor hazards.
  always_comb begin
    live = '0;
    for (int s = 2; s < NUM_STAGES; s++)
      live[s] = e_valid[s] & e_we[s] & (e_wa[s] != '0);
  end

  // Scan oldest to youngest so the youngest matching writer wins.
  always_comb begin
    fwd_sel0 = '0;
    fwd_sel1 = '0;
    for (int s = NUM_STAGES - 1; s >= 2; s--) begin
      if (d_use0 && live[s] && (e_wa[s] == d_ra0)) fwd_sel0 = FWD_W'(s - 1);
      if (d_use1 && live[s] && (e_wa[s] == d_ra1)) fwd_sel1 = FWD_W'(s - 1);
    end
  end

  assign busy     = (cnt != '0);
  assign load_use = d_valid & live[2] & e_load[2] &
                    ((d_use0 & (d_ra0 == e_wa[2])) | (d_use1 & (d_ra1 == e_wa[2])));

  always_comb begin
    stall = '0;
    flush = '0;
    if (branch_taken) begin
      for (int s = 1; s <= BRANCH_STAGE; s++) flush[s] = 1'b1;
    end else if (busy) begin
      stall[2:0] = 3'b111;
      flush[3]   = 1'b1;
    end else if (load_use) begin
      stall[1:0] = 2'b11;
      flush[2]   = 1'b1;
    end
  end

  assign mc_enter  = d_valid & d_multicycle & ~flush[2] & ~stall[2];
  assign mc_cancel = branch_taken & (BRANCH_STAGE > 2) & e_valid[2] & e_mc[2];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      e_valid      <= '0;
      e_we         <= '0;
      e_load       <= '0;
      e_mc         <= '0;
      for (int s = 2; s < NUM_STAGES; s++) e_wa[s] <= '0;
      cnt          <= '0;
      stall_cycles <= '0;
    end else begin
      if (flush[2]) begin
        e_valid[2] <= 1'b0;
      end else if (!stall[2]) begin
        e_valid[2] <= d_valid;
        e_we[2]    <= d_rf_we;
        e_wa[2]    <= d_wa;
        e_load[2]  <= d_is_load;
        e_mc[2]    <= d_multicycle;
      end
      for (int s = 3; s < NUM_STAGES; s++) begin
        if (flush[s]) begin
          e_valid[s] <= 1'b0;
        end else if (!stall[s]) begin
          e_valid[s] <= e_valid[s-1];
          e_we[s]    <= e_we[s-1];
          e_wa[s]    <= e_wa[s-1];
          e_load[s]  <= e_load[s-1];
          e_mc[s]    <= e_mc[s-1];
        end
      end

      if (mc_cancel)     cnt <= '0;
      else if (busy)     cnt <= cnt - CNT_W'(1);
      else if (mc_enter) cnt <= CNT_INIT;

      if (clear_stats)
        stall_cycles <= '0;
      else if ((|stall) && (stall_cycles != 16'hFFFF))
        stall_cycles <= stall_cycles + 16'd1;
    end
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Parametrised hazard, forwarding and stall/flush controller for the N-stage MIPS pipeline.
- Stage/register index convention: 0 = PC/fetch register, 1 = decode register, 2 = execute register, …, NUM_STAGES-1 = writeback register.
- Keeps a destination scoreboard for every in-flight instruction in stages 2..NUM_STAGES-1.
- Produces per-stage stall/flush vectors, decode-operand forwarding selects, a multicycle-execute lock and a stall performance counter.
- Lets the datapath run dependent code, loads, branches and multicycle ALU ops without software NOPs.

Parameters:
- NUM_STAGES, 5, pipeline depth including fetch; legal range 4..8.
- REG_AW, 5, register address width.
- BRANCH_STAGE, 3, stage index where branch/jump redirect is resolved; legal range 2..NUM_STAGES-1.
- MC_LAT, 4, execute-stage occupancy in cycles for multicycle ops (mult/div); value 1 means no lock.
- FWD_W, $clog2(NUM_STAGES-1), forward select width.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- d_valid  in  1  decode stage holds a real instruction
- d_ra0, d_ra1  in  REG_AW  decode source addresses
- d_use0, d_use1  in  1  source actually read
- d_rf_we  in  1  decode instruction writes RF
- d_wa  in  REG_AW  resolved write address (after sel_wa)
- d_is_load  in  1  decode instruction is a load
- d_multicycle  in  1  decode instruction is a multicycle op
- branch_taken  in  1  redirect taken by instruction in BRANCH_STAGE
- clear_stats  in  1  synchronous clear of stall_cycles
- stall  out  NUM_STAGES  stall[s]=1: register s holds its value
- flush  out  NUM_STAGES  flush[s]=1: register s loads a bubble
- fwd_sel0, fwd_sel1  out  FWD_W  0 = RF; k = value from stage k+1
- busy  out  1  multicycle lock active
- stall_cycles  out  16  count of cycles with any stall bit set

Behaviour:
- Interface: single clock `clock`; `reset` asynchronous, active-high.
- Reset: all scoreboard entries invalid, mc counter 0, stall_cycles 0. With an invalid scoreboard, all of stall, flush, fwd_sel and busy evaluate to 0.
- Scoreboard entry e[s], s = 2..NUM_STAGES-1, holds {valid, we, wa, is_load, mc}.
- Each clock, per register s:
  - flush[s] → e[s] invalid.
  - else stall[s] → e[s] holds.
  - else e[s] ← e[s-1], with e[2] ← decode inputs; e[2].valid = d_valid.
  - Last entry retires.
- Live writer: valid & we & wa != 0. Register 0 never forwards or hazards.
- Forwarding (combinational, per operand): youngest matching live writer in stages 2..NUM_STAGES-1 gives fwd_sel = s-1. No match or use=0 → 0. Entries in stages ≤ BRANCH_STAGE-1 that are being flushed this cycle still forward (decode is flushed too).
- Load-use: e[2] live load matching a used decode source, and busy=0 → stall[0]=stall[1]=1, flush[2]=1 for exactly one cycle. The next cycle the match is in stage 3, giving fwd_sel=2.
- Multicycle lock (counter cnt):
  - When an instruction with mc=1 is written into e[2], cnt ← MC_LAT-1.
  - While cnt != 0: busy=1, stall[0..2]=1, flush[3]=1, cnt decrements each cycle.
  - The op advances on the cycle cnt reaches 0 (busy low).
- Branch: branch_taken → flush[1..BRANCH_STAGE]=1, all stall bits 0. If e[2] holds an mc op and BRANCH_STAGE > 2, cnt ← 0.
- Priority: branch_taken > multicycle lock > load-use. Simultaneous load-use during busy is deferred until busy drops.
- flush and stall are never both 1 for the same bit. Unlisted bits are 0.
- stall_cycles: +1 on any cycle with |stall, saturating at 16'hFFFF. clear_stats wins over increment.
- Reset asserted mid-lock or mid-stall: immediate return to reset state; no partial flush is remembered.

Test Plan:
- add $3,$1,$2 then add $4,$3,$3 → with the second in decode, fwd_sel0=fwd_sel1=1, no stall. Insert one instruction between them → both selects =2.
- lw $5,0($0) then add $6,$5,$1 → one cycle stall=5'b00011, flush=5'b00100; next cycle fwd_sel0=2; stall_cycles=1.
- mult (d_multicycle=1), MC_LAT=4, dependent instruction following → busy high 3 cycles, stall=5'b00111, flush=5'b01000 each, then normal flow; stall_cycles=3.
- branch_taken pulse with load-use pending in decode → flush=5'b01110, stall=0; the load-use stall is suppressed.
- Writer to $0 followed by a reader of $0 → fwd_sel=0, no stall.
- Reset asserted on 2nd cycle of busy → busy, stall and flush go to 0 asynchronously; stall_cycles=0; clear_stats at 16'hFFFF → 0.
